// File: rtl/da_lut_loader_if.sv
// da_lut_loader_if: coefficient handshake and LUT RAM port bundle for the DA LUT loader.
// Signals:
//   start      - begin a load (sampled in IDLE)
//   coef_in    - signed coefficient, i-th accepted word is coef[i]
//   coef_valid - coef_in valid;  coef_ready - loader accepts this cycle
//   ram_addr   - RAM address (read and write);  ram_din - RAM write data
//   ram_we     - RAM write enable;  ram_dout - RAM asynchronous read data
//   busy       - loader not idle;  done - one-cycle fill-complete pulse
// master: loader side; slave: coefficient source / RAM side.
interface da_lut_loader_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int COEF_WIDTH = 8,
    parameter int DATA_WIDTH = 12
);
    logic                  start;
    logic [COEF_WIDTH-1:0] coef_in;
    logic                  coef_valid;
    logic                  coef_ready;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_dout;
    logic                  busy;
    logic                  done;
    modport master (
        input  start, coef_in, coef_valid, ram_dout,
        output coef_ready, ram_addr, ram_din, ram_we, busy, done
    );
    modport slave (
        output start, coef_in, coef_valid, ram_dout,
        input  coef_ready, ram_addr, ram_din, ram_we, busy, done
    );
endinterface

// File: rtl/da_lut_loader.sv
// da_lut_loader: collects ADDR_WIDTH signed coefficients, then fills the DA partial-sum LUT RAM.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   lut_if - da_lut_loader_if.master: coefficient handshake, RAM port, busy/done
// Entry k is built as RAM[base(k)] + coef[m], where m is the top set bit of k and
// base(k) is k with that bit cleared, so every entry costs one read and one write.
module da_lut_loader #(
    parameter int ADDR_WIDTH = 4,
    parameter int COEF_WIDTH = 8,
    parameter int DATA_WIDTH = 12
) (
    input logic              clk,
    input logic              rst,
    da_lut_loader_if.master  lut_if
);
    localparam int IW = ADDR_WIDTH > 1 ? $clog2(ADDR_WIDTH) : 1;
    typedef enum logic [2:0] {IDLE, COEF, ZERO, RD, WR, DONE} state_t;
    state_t                       state_q, state_d;
    logic [IW-1:0]                idx_q, idx_d, m;
    logic [ADDR_WIDTH-1:0]        k_q, k_d, base;
    logic [DATA_WIDTH-1:0]        sum_q, sum_d;
    logic signed [COEF_WIDTH-1:0] coef_q [ADDR_WIDTH];
    logic signed [COEF_WIDTH-1:0] coef_d [ADDR_WIDTH];
    // highest set bit of k and k with that bit removed
    always_comb begin
        m = '0;
        for (int i = 0; i < ADDR_WIDTH; i++)
            if (k_q[i]) m = IW'(i);
        base = k_q;
        base[m] = 1'b0;
    end
    always_comb begin
        state_d           = state_q;
        idx_d             = idx_q;
        k_d               = k_q;
        sum_d             = sum_q;
        coef_d            = coef_q;
        lut_if.coef_ready = 1'b0;
        lut_if.ram_addr   = '0;
        lut_if.ram_din    = '0;
        lut_if.ram_we     = 1'b0;
        lut_if.busy       = state_q != IDLE;
        lut_if.done       = 1'b0;
        case (state_q)
            IDLE: if (lut_if.start) begin
                state_d = COEF;
                idx_d   = '0;
            end
            COEF: begin
                lut_if.coef_ready = 1'b1;
                if (lut_if.coef_valid) begin
                    coef_d[idx_q] = lut_if.coef_in;
                    idx_d         = idx_q + 1'b1;
                    if (idx_q == IW'(ADDR_WIDTH - 1)) state_d = ZERO;
                end
            end
            ZERO: begin
                lut_if.ram_we = 1'b1;
                k_d           = ADDR_WIDTH'(1);
                state_d       = RD;
            end
            RD: begin
                lut_if.ram_addr = base;
                // size cast of a signed coefficient sign-extends; the add wraps at DATA_WIDTH
                sum_d           = lut_if.ram_dout + DATA_WIDTH'(coef_q[m]);
                state_d         = WR;
            end
            WR: begin
                lut_if.ram_addr = k_q;
                lut_if.ram_din  = sum_q;
                lut_if.ram_we   = 1'b1;
                state_d         = &k_q ? DONE : RD;
                k_d             = &k_q ? k_q : k_q + 1'b1;
            end
            DONE: begin
                lut_if.done = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            k_q     <= '0;
            sum_q   <= '0;
            coef_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            sum_q   <= sum_d;
            coef_q  <= coef_d;
        end
    end
endmodule

// File: tb/tb_da_lut_loader.sv
// tb_da_lut_loader: drives two loaders (12-bit and 8-bit LUT entries) from one stimulus stream and checks them against subset-sum tables.
module tb_da_lut_loader;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, coef_valid = 1'b0, fill = 1'b0;
    logic [7:0] coef_in = '0;
    int         checks = 0, failures = 0;
    int         wr_a = 0;
    logic [11:0] ram_a [16];
    logic [7:0]  ram_b [16];
    int          done_cyc, done_cnt, busy_low, ready_err, wr0;
    logic        post_busy, post_we;
    always #5 clk = ~clk;
    da_lut_loader_if #(.ADDR_WIDTH(4), .COEF_WIDTH(8), .DATA_WIDTH(12)) bus_a ();
    da_lut_loader_if #(.ADDR_WIDTH(4), .COEF_WIDTH(8), .DATA_WIDTH(8))  bus_b ();
    assign bus_a.start = start;
    assign bus_a.coef_in = coef_in;
    assign bus_a.coef_valid = coef_valid;
    assign bus_a.ram_dout = ram_a[bus_a.ram_addr];
    assign bus_b.start = start;
    assign bus_b.coef_in = coef_in;
    assign bus_b.coef_valid = coef_valid;
    assign bus_b.ram_dout = ram_b[bus_b.ram_addr];
    da_lut_loader #(.ADDR_WIDTH(4), .COEF_WIDTH(8), .DATA_WIDTH(12)) dut_a (.clk(clk), .rst(rst), .lut_if(bus_a));
    da_lut_loader #(.ADDR_WIDTH(4), .COEF_WIDTH(8), .DATA_WIDTH(8))  dut_b (.clk(clk), .rst(rst), .lut_if(bus_b));
    // RAM models: write on the clock edge, asynchronous read above; fill loads sentinels
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 16; i++) begin
                ram_a[i] <= 12'hA5A;
                ram_b[i] <= 8'h5A;
            end
        end else begin
            if (bus_a.ram_we) begin
                ram_a[bus_a.ram_addr] <= bus_a.ram_din;
                wr_a <= wr_a + 1;
            end
            if (bus_b.ram_we) ram_b[bus_b.ram_addr] <= bus_b.ram_din;
        end
    end
    // entry k = sum of coefficients whose index bit is set in k
    function automatic int model(input int k, input int c[4]);
        int s = 0;
        for (int i = 0; i < 4; i++)
            if (k[i]) s += c[i];
        return s;
    endfunction
    task automatic prefill();
        @(negedge clk) fill = 1'b1;
        @(negedge clk) fill = 1'b0;
    endtask
    // Runs one load; cycle j is observed at the j-th falling edge after the start-sampling edge.
    task automatic load(input int c[4], input int stall_at, input int stall_len, input int pulse_at,
                        input int hold_from, input int rst_at, input bit cont);
        int n = 0, left = stall_len;
        bit v;
        done_cyc = -1; done_cnt = 0; busy_low = -1; ready_err = 0; wr0 = wr_a;
        if (!cont) begin
            @(negedge clk);
            start = 1'b1;
            coef_valid = 1'b0;
        end
        @(posedge clk);
        for (int j = 1; j <= 200; j++) begin
            @(negedge clk);
            if (j == 1) start = 1'b0;
            if (j == pulse_at) start = 1'b1;
            if (j == pulse_at + 1) start = 1'b0;
            if (hold_from > 0 && j >= hold_from) start = 1'b1;
            if (bus_a.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = j;
            end
            if (!bus_a.busy && busy_low < 0) busy_low = j;
            if (bus_a.coef_ready !== (n < 4)) ready_err++;
            if (rst_at > 0 && j == rst_at + 1) begin
                post_busy = bus_a.busy;
                post_we = bus_a.ram_we;
                rst = 1'b0;
                break;
            end
            if (done_cyc > 0 && j == done_cyc + 1) break;
            if (j == rst_at) rst = 1'b1;
            if (n == stall_at && left > 0) begin
                v = 1'b0;
                left--;
            end else v = 1'b1;
            coef_valid = v;
            coef_in = (v && n < 4) ? 8'(c[n]) : 8'($urandom);
            if (v && n < 4) n++;
        end
        coef_valid = 1'b0;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus_a.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0d exp=0", bus_a.busy); end
        checks++; if (bus_a.coef_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0d exp=0", bus_a.coef_ready); end
        checks++; if (bus_a.ram_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%0d exp=0", bus_a.ram_we); end
        checks++; if (bus_a.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0d exp=0", bus_a.done); end
        checks++; if (bus_a.ram_addr !== 4'd0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", bus_a.ram_addr); end
        checks++; if (bus_a.ram_din !== 12'd0) begin failures++; $display("FAIL reset_din got=%0h exp=0", bus_a.ram_din); end
        rst = 1'b0;
    endtask
    task automatic test_identity();
        int c[4];
        c = '{1, 2, 4, 8};
        prefill();
        load(c, -1, 0, 0, 0, 0, 1'b0);
        checks++; if (done_cyc !== 36) begin failures++; $display("FAIL id_done_cycle got=%0d exp=36", done_cyc); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL id_done_count got=%0d exp=1", done_cnt); end
        checks++; if (busy_low !== 37) begin failures++; $display("FAIL id_busy_first_low got=%0d exp=37", busy_low); end
        checks++; if (ready_err !== 0) begin failures++; $display("FAIL id_ready got=%0d errors exp=0", ready_err); end
        checks++; if (wr_a - wr0 !== 16) begin failures++; $display("FAIL id_writes got=%0d exp=16", wr_a - wr0); end
        for (int k = 0; k < 16; k++) begin
            checks++; if (ram_a[k] !== 12'(k)) begin failures++; $display("FAIL id_ram[%0d] got=%0h exp=%0h", k, ram_a[k], k); end
        end
    endtask
    task automatic test_signed();
        int c[4];
        c = '{-1, -2, 3, 5};
        prefill();
        load(c, -1, 0, 0, 0, 0, 1'b0);
        checks++; if (ram_a[3] !== 12'hFFD) begin failures++; $display("FAIL sg_ram3 got=%0h exp=ffd", ram_a[3]); end
        checks++; if (ram_a[12] !== 12'd8) begin failures++; $display("FAIL sg_ram12 got=%0h exp=8", ram_a[12]); end
        checks++; if (ram_a[15] !== 12'd5) begin failures++; $display("FAIL sg_ram15 got=%0h exp=5", ram_a[15]); end
        checks++; if (ram_a[0] !== 12'd0) begin failures++; $display("FAIL sg_ram0 got=%0h exp=0", ram_a[0]); end
        for (int k = 0; k < 16; k++) begin
            checks++; if (ram_b[k] !== 8'(model(k, c))) begin failures++; $display("FAIL sg_ramb[%0d] got=%0h exp=%0h", k, ram_b[k], 8'(model(k, c))); end
        end
    endtask
    task automatic test_stall();
        int c[4];
        logic [11:0] snap [16];
        for (int i = 0; i < 4; i++) c[i] = int'($urandom_range(0, 255)) - 128;
        load(c, -1, 0, 0, 0, 0, 1'b0);
        snap = ram_a;
        prefill();
        load(c, 2, 3, 0, 0, 0, 1'b0);
        checks++; if (done_cyc !== 39) begin failures++; $display("FAIL st_done_cycle got=%0d exp=39", done_cyc); end
        checks++; if (ready_err !== 0) begin failures++; $display("FAIL st_ready got=%0d errors exp=0", ready_err); end
        for (int k = 0; k < 16; k++) begin
            checks++; if (ram_a[k] !== snap[k] || ram_a[k] !== 12'(model(k, c))) begin failures++; $display("FAIL st_ram[%0d] got=%0h exp=%0h", k, ram_a[k], 12'(model(k, c))); end
        end
    endtask
    task automatic test_start_busy();
        int c[4], d[4];
        c = '{7, -9, 20, -33};
        d = '{-50, 11, 2, 90};
        prefill();
        load(c, -1, 0, 12, 30, 0, 1'b0);
        checks++; if (done_cyc !== 36) begin failures++; $display("FAIL sb_done_cycle got=%0d exp=36", done_cyc); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL sb_done_count got=%0d exp=1", done_cnt); end
        checks++; if (busy_low !== 37) begin failures++; $display("FAIL sb_busy_first_low got=%0d exp=37", busy_low); end
        checks++; if (wr_a - wr0 !== 16) begin failures++; $display("FAIL sb_writes got=%0d exp=16", wr_a - wr0); end
        for (int k = 0; k < 16; k++) begin
            checks++; if (ram_a[k] !== 12'(model(k, c))) begin failures++; $display("FAIL sb_ram[%0d] got=%0h exp=%0h", k, ram_a[k], 12'(model(k, c))); end
        end
        load(d, -1, 0, 0, 0, 0, 1'b1);
        checks++; if (done_cyc !== 36) begin failures++; $display("FAIL sb2_done_cycle got=%0d exp=36", done_cyc); end
        checks++; if (ready_err !== 0) begin failures++; $display("FAIL sb2_ready got=%0d errors exp=0", ready_err); end
        for (int k = 0; k < 16; k++) begin
            checks++; if (ram_a[k] !== 12'(model(k, d))) begin failures++; $display("FAIL sb2_ram[%0d] got=%0h exp=%0h", k, ram_a[k], 12'(model(k, d))); end
        end
    endtask
    task automatic test_reset_midfill();
        int c[4];
        c = '{3, 6, 12, 24};
        prefill();
        load(c, -1, 0, 0, 0, 17, 1'b0);
        checks++; if (post_busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%0d exp=0", post_busy); end
        checks++; if (post_we !== 1'b0) begin failures++; $display("FAIL rm_we got=%0d exp=0", post_we); end
        repeat (5) @(negedge clk);
        checks++; if (wr_a - wr0 !== 7) begin failures++; $display("FAIL rm_writes got=%0d exp=7", wr_a - wr0); end
        checks++; if (ram_a[6] !== 12'(model(6, c))) begin failures++; $display("FAIL rm_ram6 got=%0h exp=%0h", ram_a[6], 12'(model(6, c))); end
        checks++; if (ram_a[7] !== 12'hA5A) begin failures++; $display("FAIL rm_ram7 got=%0h exp=a5a", ram_a[7]); end
        c = '{-100, 45, -7, 66};
        load(c, -1, 0, 0, 0, 0, 1'b0);
        checks++; if (done_cyc !== 36) begin failures++; $display("FAIL rm2_done_cycle got=%0d exp=36", done_cyc); end
        for (int k = 0; k < 16; k++) begin
            checks++; if (ram_a[k] !== 12'(model(k, c))) begin failures++; $display("FAIL rm2_ram[%0d] got=%0h exp=%0h", k, ram_a[k], 12'(model(k, c))); end
        end
    endtask
    task automatic test_wrap();
        int c[4];
        c = '{127, 127, 127, 127};
        prefill();
        load(c, -1, 0, 0, 0, 0, 1'b0);
        checks++; if (ram_b[15] !== 8'hFC) begin failures++; $display("FAIL wr_ramb15 got=%0h exp=fc", ram_b[15]); end
        checks++; if (ram_b[3] !== 8'hFE) begin failures++; $display("FAIL wr_ramb3 got=%0h exp=fe", ram_b[3]); end
        checks++; if (ram_a[15] !== 12'd508) begin failures++; $display("FAIL wr_rama15 got=%0h exp=1fc", ram_a[15]); end
        for (int k = 0; k < 16; k++) begin
            checks++; if (ram_b[k] !== 8'(model(k, c))) begin failures++; $display("FAIL wr_ramb[%0d] got=%0h exp=%0h", k, ram_b[k], 8'(model(k, c))); end
        end
    endtask
    task automatic test_random();
        int c[4];
        int sa, sl;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) c[i] = int'($urandom_range(0, 255)) - 128;
            sa = int'($urandom_range(0, 3));
            sl = int'($urandom_range(0, 3));
            prefill();
            load(c, sa, sl, 0, 0, 0, 1'b0);
            checks++; if (done_cyc !== 36 + sl) begin failures++; $display("FAIL rnd_done_cycle got=%0d exp=%0d", done_cyc, 36 + sl); end
            checks++; if (ready_err !== 0) begin failures++; $display("FAIL rnd_ready got=%0d errors exp=0", ready_err); end
            for (int k = 0; k < 16; k++) begin
                checks++; if (ram_a[k] !== 12'(model(k, c))) begin failures++; $display("FAIL rnd_ram[%0d] got=%0h exp=%0h", k, ram_a[k], 12'(model(k, c))); end
                checks++; if (ram_b[k] !== 8'(model(k, c))) begin failures++; $display("FAIL rnd_ramb[%0d] got=%0h exp=%0h", k, ram_b[k], 8'(model(k, c))); end
            end
        end
    endtask
    initial begin
        test_reset();
        test_identity();
        test_signed();
        test_stall();
        test_start_busy();
        test_reset_midfill();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/da_lut_loader.md
# da_lut_loader

Initiator and writer for the distributed-arithmetic partial-sum LUT RAM, a one-port RAM with asynchronous read. It accepts ADDR_WIDTH signed coefficients over a valid/ready handshake. It then fills all 2^ADDR_WIDTH RAM entries so that entry k holds the sum of the coefficients whose index bit is set in k. It sits between the coefficient source and the RAM's din/addr/we/dout port, and owns that port while busy.

## Interface
- ADDR_WIDTH, 4: number of taps; LUT depth is 2^ADDR_WIDTH.
- COEF_WIDTH, 8: coefficient width, signed two's complement.
- DATA_WIDTH, 12: LUT entry width. Must be ≥ COEF_WIDTH + clog2(ADDR_WIDTH) for exact sums; otherwise sums wrap.

Ports:
- clk  in  1  sole clock; everything updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE.
- coef_in  in  COEF_WIDTH  coefficient; the i-th accepted word is coef[i], i = 0..ADDR_WIDTH-1.
- coef_valid  in  1  coef_in is valid.
- coef_ready  out  1  loader accepts coef_in this cycle.
- ram_addr  out  ADDR_WIDTH  RAM address, used for both read and write.
- ram_din  out  DATA_WIDTH  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_dout  in  DATA_WIDTH  RAM asynchronous read data for ram_addr.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the fill completes.

## Operation
- The state machine has six states: IDLE, COEF, ZERO, RD, WR, DONE.
- **IDLE:** if start = 1, go to COEF and clear the coefficient index to 0.
- **COEF:**
  - coef_ready = 1.
  - On coef_valid & coef_ready, store coef_in into coef[idx] and increment idx.
  - After the ADDR_WIDTH-th accept, go to ZERO. There is no timeout; the loader waits indefinitely on coef_valid.
- **ZERO** (one cycle): ram_addr = 0, ram_din = 0, ram_we = 1. Set k = 1 and go to RD.
- **RD** (one cycle):
  - ram_addr = base(k), ram_we = 0, where base(k) = k with its highest set bit cleared and m = index of that bit.
  - Register sum = ram_dout + sext(coef[m]) at the clock edge, then go to WR.
- **WR** (one cycle):
  - ram_addr = k, ram_din = sum, ram_we = 1.
  - If k = 2^ADDR_WIDTH-1, go to DONE; otherwise increment k and go to RD.
- **DONE** (one cycle): done = 1, then go to IDLE.
- **Arithmetic:** coefficients are sign-extended to DATA_WIDTH. The addition is modulo 2^DATA_WIDTH, with no saturation and no overflow flag.
- **Data dependency:** base(k) < k always, so base(k) was written earlier in the same fill.
- **Ignored inputs:**
  - start while busy is ignored; no restart and no queuing.
  - coef_valid outside COEF is ignored, and coef_ready = 0 there.
- **Reset** (any state, including mid-fill):
  - Next cycle: state = IDLE, idx = k = sum = 0, coef[] = 0.
  - All outputs are 0: coef_ready, ram_addr, ram_din, ram_we, busy, done.
  - RAM contents are left as written so far. The loader never clears the RAM; the RAM's own reset handles that.
- ram_we is asserted only in ZERO and WR.

## Timing
- Outputs are registered-state decodes: ram_addr, ram_din and ram_we are valid for the whole cycle in which the state is current.
- Cycle 0 is the edge where start is sampled in IDLE.
- With coef_valid held high, coefficients are accepted in cycles 1..ADDR_WIDTH.
- ZERO occurs at cycle ADDR_WIDTH+1.
- RD/WR pairs occupy 2·(2^ADDR_WIDTH−1) cycles.
- done is asserted in the following cycle: cycle 36 for defaults (ZERO at 5, pairs at 6..35).
- Each cycle of coef_valid low during COEF delays everything after it by one cycle.
- Fill latency is fixed at 1 + 2·(2^ADDR_WIDTH−1) cycles after the last coefficient accept.
- The earliest next start is sampled in the cycle after DONE (IDLE).

## Test plan
- **Identity LUT:** defaults, coefs 1,2,4,8 streamed back-to-back → RAM[k] = k for all k = 0..15; done is high exactly at cycle 36, for one cycle; busy is high over cycles 1..36.
- **Signed coefficients:** coefs −1,−2,3,5 → RAM[3] = 0xFFD (−3), RAM[12] = 8, RAM[15] = 5, RAM[0] = 0.
- **Stalled handshake:** coef_valid low for 3 cycles between coef[1] and coef[2] → no accept while low; done arrives at cycle 39; contents match the unstalled run.
- **start while busy:** pulse start during RD/WR → no effect on the sequence, done count, or contents; a start held through DONE begins a second load from IDLE.
- **Reset mid-fill:** assert Reset at the WR for k = 6 → next cycle busy = 0 and ram_we = 0; no further RAM writes; a following full load overwrites every entry correctly.
- **Wrap-around:** DATA_WIDTH = 8, coefs 127 ×4 → RAM[15] = 508 mod 256 = 0xFC, RAM[3] = 0xFE.
